// File: rtl/route_writer_if.sv
// Route stream / route RAM write bus for route_writer.
// slave  : the writer's view (consumes the beat stream, drives the RAM port).
// master : the environment's view (drives the beat stream, observes RAM writes).
interface route_writer_if #(
    parameter int CITY_W = 7,
    parameter int ADDR_W = 3
);
    logic                  in_valid;
    logic [8*CITY_W-1:0]   in_data;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [8*CITY_W-1:0]   mem_wdata;

    modport slave (
        input  in_valid, in_data,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_data,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/route_writer.sv
// route_writer: sinks the 8-city-per-beat route stream and writes one beat per
// word into a replica's route RAM. Bubbles are free; done pulses with the last
// write. Optional permutation check enabled by defining ROUTE_WRITER_CHECK_EN.
module route_writer #(
    parameter int CITY_NUM = 64,
    parameter int CITY_W   = 7,
    parameter int ADDR_W   = $clog2(CITY_NUM/8)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    route_writer_if.slave   bus,
    output logic            busy,
    output logic            done,
    output logic            err_stray,
    output logic            err_dup
);
    localparam int BEATS  = CITY_NUM / 8;
    localparam int BEAT_W = 8 * CITY_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BEATS - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   wcnt, wcnt_d;
    logic                accept, last;

    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                stray_q, stray_d;

    // start always takes priority: a beat coincident with start is ignored
    assign accept = (state == RECV) && bus.in_valid && !start;
    assign last   = accept && (wcnt == LAST);

    // state register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wcnt    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            state   <= state_d;
            wcnt    <= wcnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            stray_q <= stray_d;
        end
    end

    // next-state: start re-arms from either state, last beat returns to IDLE
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (start) state_d = RECV;
            RECV: if (!start && last) state_d = IDLE;
        endcase
    end

    // output / datapath next values
    always_comb begin
        wcnt_d  = wcnt;
        if (start)
            wcnt_d = '0;
        else if (accept)
            wcnt_d = last ? '0 : wcnt + ADDR_W'(1);
        we_d    = accept;
        addr_d  = accept ? wcnt : addr_q;
        wdata_d = accept ? bus.in_data : wdata_q;
        done_d  = last;
        busy_d  = (state_d == RECV);
        stray_d = stray_q;
        if (start)
            stray_d = 1'b0;
        else if (state == IDLE && bus.in_valid)
            stray_d = 1'b1;
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_stray     = stray_q;

`ifdef ROUTE_WRITER_CHECK_EN
    localparam logic [CITY_NUM-1:0] ONE = CITY_NUM'(1);

    logic [CITY_NUM-1:0]          seen, beat_mask;
    logic [7:0][CITY_NUM-1:0]     lane_oh;
    logic [7:0]                   lane_bad;
    logic                         err_dup_q;

    // per lane: out of range, already in the bitmap, or equal to a lower lane
    for (genvar i = 0; i < 8; i++) begin : g_lane
        logic [CITY_W-1:0] city;
        logic              eq_low;
        assign city       = bus.in_data[i*CITY_W +: CITY_W];
        assign lane_oh[i] = ONE << city;
        // compare against every lower lane of the same beat
        always_comb begin
            eq_low = 1'b0;
            for (int j = 0; j < i; j++)
                if (bus.in_data[j*CITY_W +: CITY_W] == city) eq_low = 1'b1;
        end
        assign lane_bad[i] = (int'(city) >= CITY_NUM) || (|(seen & lane_oh[i])) || eq_low;
    end

    // union of the lanes of the current beat
    always_comb begin
        beat_mask = '0;
        for (int i = 0; i < 8; i++) beat_mask = beat_mask | lane_oh[i];
    end

    // seen-bitmap and sticky duplicate flag; the write happens regardless
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen      <= '0;
            err_dup_q <= 1'b0;
        end else if (start) begin
            seen      <= '0;
            err_dup_q <= 1'b0;
        end else if (accept) begin
            seen <= seen | beat_mask;
            if (|lane_bad) err_dup_q <= 1'b1;
        end
    end

    assign err_dup = err_dup_q;
`else
    assign err_dup = 1'b0;
`endif
endmodule

// File: tb/tb_route_writer.sv
// Directed bench for route_writer (CITY_NUM=64): back-to-back and bubbled
// routes, stray beats, abort/re-arm, start on the last beat, duplicate check
// (when ROUTE_WRITER_CHECK_EN is defined) and reset mid-route.
module tb_route_writer;
    localparam int CITY_NUM = 64;
    localparam int CITY_W   = 7;
    localparam int ADDR_W   = 3;
    localparam int BEAT_W   = 8 * CITY_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done, err_stray, err_dup;

    int checks = 0;
    int failures = 0;
    int n_done = 0;

    route_writer_if #(.CITY_W(CITY_W), .ADDR_W(ADDR_W)) bus ();

    route_writer #(.CITY_NUM(CITY_NUM), .CITY_W(CITY_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err_stray (err_stray),
        .err_dup   (err_dup)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge and sample 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) n_done++;
    endtask

    // beat b of the identity route: lanes 8b..8b+7
    function automatic logic [BEAT_W-1:0] mk_beat(input int b);
        logic [BEAT_W-1:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) d[i*CITY_W +: CITY_W] = CITY_W'(8*b + i);
        return d;
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_we", bus.mem_we, 0);
        chk("start_stray", err_stray, 0);
        chk("start_dup", err_dup, 0);
    endtask

    task automatic send_beat(input logic [BEAT_W-1:0] d, input int addr, input bit last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        chk("we", bus.mem_we, 1);
        chk("addr", bus.mem_addr, 64'(addr));
        chk("wdata", bus.mem_wdata, 64'(d));
        chk("done", done, 64'(last));
        chk("busy", busy, 64'(!last));
    endtask

    task automatic bubble(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            chk("bubble_we", bus.mem_we, 0);
            chk("bubble_busy", busy, 1);
        end
    endtask

    // full identity route with bubbles after beats 3 and 6
    task automatic send_route(input int gap3, input int gap6);
        for (int b = 0; b < 8; b++) begin
            send_beat(mk_beat(b), b, b == 7);
            if (b == 3) bubble(gap3);
            if (b == 6) bubble(gap6);
        end
        tick();
        chk("post_we", bus.mem_we, 0);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, bus.mem_we, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_stray"}, err_stray, 0);
        chk({tag, "_dup"}, err_dup, 0);
    endtask

    initial begin
        int d0;
        logic [BEAT_W-1:0] bad;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // reset state
        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b0;
        tick();
        chk_all_zero("idle");

        // back-to-back route
        d0 = n_done;
        do_start();
        send_route(0, 0);
        chk("b2b_ndone", 64'(n_done - d0), 1);
        chk("b2b_dup", err_dup, 0);

        // bubbled route
        d0 = n_done;
        do_start();
        send_route(1, 5);
        chk("bub_ndone", 64'(n_done - d0), 1);
        chk("bub_stray", err_stray, 0);
        chk("bub_dup", err_dup, 0);

        // stray beat in IDLE: no write, sticky flag
        bus.in_valid = 1'b1;
        bus.in_data  = mk_beat(2);
        tick();
        bus.in_valid = 1'b0;
        chk("stray_we", bus.mem_we, 0);
        chk("stray_flag", err_stray, 1);
        tick();
        tick();
        chk("stray_sticky", err_stray, 1);
        chk("stray_busy", busy, 0);

        // start with a coincident beat: beat ignored, stray cleared
        d0 = n_done;
        start = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b0;
        chk("st_iv_we", bus.mem_we, 0);
        chk("st_iv_stray", err_stray, 0);
        chk("st_iv_busy", busy, 1);

        // 3 beats, abort with start (+coincident beat), then a full route
        for (int b = 0; b < 3; b++) send_beat(mk_beat(b), b, 0);
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = mk_beat(3);
        tick();
        start = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_we", bus.mem_we, 0);
        chk("abort_busy", busy, 1);
        chk("abort_stray", err_stray, 0);
        send_route(0, 0);
        chk("abort_ndone", 64'(n_done - d0), 1);

        // start coincident with the last beat: start wins, no done
        d0 = n_done;
        do_start();
        for (int b = 0; b < 7; b++) send_beat(mk_beat(b), b, 0);
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = mk_beat(7);
        tick();
        start = 1'b0;
        bus.in_valid = 1'b0;
        chk("lastst_we", bus.mem_we, 0);
        chk("lastst_done", done, 0);
        chk("lastst_busy", busy, 1);
        send_route(0, 2);
        chk("lastst_ndone", 64'(n_done - d0), 1);

        // duplicate city: beat 2 lane 5 = 3
        d0 = n_done;
        do_start();
        send_beat(mk_beat(0), 0, 0);
        chk("dup_b0", err_dup, 0);
        send_beat(mk_beat(1), 1, 0);
        bad = mk_beat(2);
        bad[5*CITY_W +: CITY_W] = 7'd3;
        send_beat(bad, 2, 0);
`ifdef ROUTE_WRITER_CHECK_EN
        chk("dup_set", err_dup, 1);
`else
        chk("dup_set", err_dup, 0);
`endif
        for (int b = 3; b < 8; b++) send_beat(mk_beat(b), b, b == 7);
`ifdef ROUTE_WRITER_CHECK_EN
        chk("dup_sticky", err_dup, 1);
`else
        chk("dup_sticky", err_dup, 0);
`endif
        chk("dup_ndone", 64'(n_done - d0), 1);
        tick();

        // out-of-range city 64 (start also clears err_dup)
        do_start();
        bad = mk_beat(0);
        bad[0 +: CITY_W] = 7'd64;
        send_beat(bad, 0, 0);
`ifdef ROUTE_WRITER_CHECK_EN
        chk("oor_set", err_dup, 1);
`else
        chk("oor_set", err_dup, 0);
`endif

        // reset mid-route during beat 4
        do_start();
        chk("rr_dup_clr", err_dup, 0);
        for (int b = 0; b < 4; b++) send_beat(mk_beat(b), b, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = mk_beat(4);
        reset = 1'b1;
        tick();
        chk_all_zero("midrst");
        reset = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("midrst_busy", busy, 0);
        d0 = n_done;
        do_start();
        send_route(0, 0);
        chk("midrst_ndone", 64'(n_done - d0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/route_writer.md
# route_writer

Stream sink for the replica route path: accepts the 8-city-per-beat route stream produced by the route optimisation stage and writes it back, one beat per word, into a replica's route RAM. Tracks beat count, tolerates valid bubbles (including the one-cycle hole the optimiser inserts at the move-source beat), and raises `done` when a full route of `CITY_NUM` cities has been committed. Optionally checks that the written route is a permutation.

## Interface
- `CITY_NUM`, 64, cities per route; multiple of 8, ≥ 16
- `CITY_W`, 7, bits per city index; `2**CITY_W >= CITY_NUM`
- `ADDR_W`, `$clog2(CITY_NUM/8)`, route RAM word address width
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle pulse; arms the writer for a new route
- `in_valid`  in  1  beat valid
- `in_data`  in  8*CITY_W  beat; lane i at `[i*CITY_W +: CITY_W]`, lane 0 = lowest route position
- `mem_we`  out  1  route RAM write enable
- `mem_addr`  out  ADDR_W  route RAM word address
- `mem_wdata`  out  8*CITY_W  route RAM write data (lane order unchanged)
- `busy`  out  1  high from the cycle after `start` until `done`
- `done`  out  1  single-cycle pulse with the last write
- `err_stray`  out  1  sticky: `in_valid` seen while IDLE
- `err_dup`  out  1  sticky, only with `ROUTE_WRITER_CHECK_EN`: duplicate or out-of-range city

## Operation
- States: IDLE, RECV.
- IDLE: `start` → RECV, beat counter `wcnt` ← 0, sticky errors cleared. `in_valid` in IDLE is dropped (no write) and sets `err_stray`.
- RECV: each cycle with `in_valid` writes `in_data` to address `wcnt`, then `wcnt` ← `wcnt`+1. Cycles without `in_valid` are bubbles; no write, no timeout, unlimited length.
- Beat `CITY_NUM/8 - 1` accepted → `done`, return to IDLE.
- `start` in RECV: abort and re-arm; `wcnt` ← 0, errors cleared, stays RECV. Words already written are not restored. `in_valid` in the same cycle as `start` is ignored in either state and does not set `err_stray`.
- `start` coincident with the last beat: `start` wins, no `done`.
- `wcnt` is `ADDR_W` wide and never wraps inside a route; state machine leaves RECV at the last beat.
- Reset mid-route: all state to reset values immediately; partial RAM contents are left as written.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err_stray`=0, `err_dup`=0; state IDLE, `wcnt`=0.
- All outputs registered. `in_valid` at edge t → `mem_we`/`mem_addr`/`mem_wdata` valid for exactly the cycle after t.
- `done` is asserted in the same cycle as the final `mem_we`; `busy` falls in that same cycle.
- `busy` rises the cycle after `start`.
- Back-to-back beats sustain one write per cycle; no backpressure exists, and the source never stalls.
- `err_dup` rises in the cycle after the offending beat is accepted; it is reported at the same time as that beat's write.

## Configuration
- `ROUTE_WRITER_CHECK_EN` defined: a `CITY_NUM`-bit seen-bitmap is cleared on `start`. Each accepted beat sets the 8 bits of its lanes. Any lane index ≥ `CITY_NUM`, any lane already set in the bitmap, or two equal lanes in one beat sets `err_dup`. The write still happens.
- Not defined: no bitmap; `err_dup` is tied to 0.

## Test plan
- CITY_NUM=64. `start`, then 8 back-to-back beats with lanes 8b..8b+7 → writes at addresses 0..7 on cycles t+1..t+8, `done` pulses at t+8 with the addr-7 write, `busy` falls there.
- Same route with a one-cycle bubble after beat 3 and a five-cycle bubble after beat 6 → 8 writes at addresses 0..7 in order, `done` with the 8th write, no errors.
- `in_valid` with no prior `start` → no `mem_we`, `err_stray`=1 until the next `start`.
- `start`, 3 beats, `start` again, 8 beats → addresses 0,1,2,0..7 written, exactly one `done`.
- With the macro: beat 2 lane 5 = 3 (already in beat 0) → `err_dup`=1 from the cycle of beat 2's write, `done` still pulses after beat 7. Lane value 64 → `err_dup`=1.
- Assert `reset` during beat 4 → all outputs 0 next edge. A following `start` plus 8 beats completes normally.
